ni_tdm_slot_table_sequencer: RTL

// Sequences all writes into the NI TDM slot tables and the link-enable registers over the

---
 rtl/ni_tdm_cfg_pkg.sv | 39 +++
 rtl/ni_tdm_cfg_stage_fifo.sv | 64 ++++++
 rtl/ni_tdm_slot_table_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ni_tdm_cfg_pkg.sv
// Shared types and default geometry for the NI TDM slot-table configuration path.
package ni_tdm_cfg_pkg;

    localparam int DEF_CT_LINKS    = 2;
    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_LUT_SIZE    = 8;
    localparam int DEF_STAGE_DEPTH = 8;

    function automatic int lut_ports_of(input int ct_links, input int channels);
        return (channels > 2 * ct_links) ? channels : 2 * ct_links;
    endfunction

    localparam int CFG_LUT_PORTS = lut_ports_of(DEF_CT_LINKS, DEF_CHANNELS);
    localparam int CFG_SEL_W     = $clog2(CFG_LUT_PORTS);
    localparam int CFG_DATA_W    = $clog2(DEF_CHANNELS + 1);
    localparam int CFG_SLOT_W    = $clog2(DEF_LUT_SIZE);

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_LINK   = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_COMMIT = 2'd3
    } cfg_op_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLEAR      = 2'd1,
        ST_WAIT_EPOCH = 2'd2,
        ST_APPLY      = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic                  is_link;
        logic [CFG_SEL_W-1:0]  sel;
        logic [CFG_SLOT_W-1:0] slot;
        logic [CFG_DATA_W-1:0] data;
    } stage_entry_t;

endpackage

// File: rtl/ni_tdm_cfg_stage_fifo.sv
// Show-ahead FIFO holding staged WRITE/LINK commands until the next commit.
module ni_tdm_cfg_stage_fifo
    import ni_tdm_cfg_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_noc,
    input  logic             rst_noc,
    input  logic             push,
    input  stage_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output stage_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    stage_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk_noc or negedge rst_noc) begin
        if (!rst_noc) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk_noc) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/ni_tdm_slot_table_sequencer.sv
// Stages slot-table / link-enable writes and applies them as one burst at a TDM
// epoch boundary; also sweeps every slot table to "unassigned" on CLEAR.
module ni_tdm_slot_table_sequencer
    import ni_tdm_cfg_pkg::*;
#(
    parameter int  CT_LINKS    = DEF_CT_LINKS,
    parameter int  CHANNELS    = DEF_CHANNELS,
    parameter int  LUT_SIZE    = DEF_LUT_SIZE,
    parameter int  STAGE_DEPTH = DEF_STAGE_DEPTH,
    localparam int LUT_PORTS   = lut_ports_of(CT_LINKS, CHANNELS),
    localparam int SEL_W       = $clog2(LUT_PORTS),
    localparam int DATA_W      = $clog2(CHANNELS + 1),
    localparam int SLOT_W      = $clog2(LUT_SIZE)
) (
    input  logic              clk_noc,
    input  logic              rst_noc,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [SLOT_W-1:0] cmd_slot,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              epoch_start,
    output logic [DATA_W-1:0] lut_conf_data,
    output logic [SEL_W-1:0]  lut_conf_sel,
    output logic [SLOT_W-1:0] lut_conf_slot,
    output logic              lut_conf_valid,
    output logic              link_en_valid,
    output logic              busy,
    output logic              commit_done,
    output logic              stage_ovf
);

    localparam int CLR_TOTAL = LUT_PORTS * LUT_SIZE;
    localparam int CLR_W     = $clog2(CLR_TOTAL + 1);
    localparam int CNT_W     = $clog2(STAGE_DEPTH + 1);

    if (STAGE_DEPTH > LUT_SIZE) begin : g_bad_depth
        $fatal(1, "STAGE_DEPTH must not exceed LUT_SIZE");
    end
    if (SEL_W != CFG_SEL_W || DATA_W != CFG_DATA_W || SLOT_W != CFG_SLOT_W) begin : g_bad_geom
        $fatal(1, "geometry parameters disagree with ni_tdm_cfg_pkg stage_entry_t");
    end

    // Reset asserts asynchronously but releases on a clock edge.
    logic rst_meta_reg;
    logic rst_n_sync_reg;

    always_ff @(posedge clk_noc or negedge rst_noc) begin
        if (!rst_noc) begin
            rst_meta_reg   <= 1'b0;
            rst_n_sync_reg <= 1'b0;
        end else begin
            rst_meta_reg   <= 1'b1;
            rst_n_sync_reg <= rst_meta_reg;
        end
    end

    seq_state_t        state_reg,       state_next;
    logic [CLR_W-1:0]  clr_cnt_reg,     clr_cnt_next;
    logic [DATA_W-1:0] conf_data_reg,   conf_data_next;
    logic [SEL_W-1:0]  conf_sel_reg,    conf_sel_next;
    logic [SLOT_W-1:0] conf_slot_reg,   conf_slot_next;
    logic              lut_valid_reg,   lut_valid_next;
    logic              link_valid_reg,  link_valid_next;
    logic              commit_done_reg, commit_done_next;
    logic              stage_ovf_reg,   stage_ovf_next;

    cfg_op_t           op;
    stage_entry_t      push_entry;
    stage_entry_t      fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              apply_pop;

    assign op         = cfg_op_t'(cmd_op);
    assign push_entry = '{is_link: (op == OP_LINK), sel: cmd_sel, slot: cmd_slot, data: cmd_data};
    assign cmd_ready  = (state_reg == ST_IDLE) && rst_n_sync_reg;

    ni_tdm_cfg_stage_fifo #(
        .DEPTH (STAGE_DEPTH)
    ) u_stage_fifo (
        .clk_noc   (clk_noc),
        .rst_noc   (rst_n_sync_reg),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next       = state_reg;
        clr_cnt_next     = clr_cnt_reg;
        conf_data_next   = conf_data_reg;
        conf_sel_next    = conf_sel_reg;
        conf_slot_next   = conf_slot_reg;
        lut_valid_next   = 1'b0;
        link_valid_next  = 1'b0;
        commit_done_next = 1'b0;
        stage_ovf_next   = 1'b0;
        fifo_push        = 1'b0;
        fifo_pop         = 1'b0;
        fifo_flush       = 1'b0;
        apply_pop        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    case (op)
                        OP_WRITE, OP_LINK: begin
                            if (fifo_full) stage_ovf_next = 1'b1;
                            else           fifo_push      = 1'b1;
                        end
                        OP_CLEAR: begin
                            // First sweep strobe (port 0, slot 0) goes out with the acceptance edge.
                            fifo_flush     = 1'b1;
                            state_next     = ST_CLEAR;
                            clr_cnt_next   = CLR_W'(1);
                            lut_valid_next = 1'b1;
                            conf_data_next = DATA_W'(CHANNELS);
                            conf_sel_next  = '0;
                            conf_slot_next = '0;
                        end
                        default: begin
                            if (fifo_count == '0) commit_done_next = 1'b1;
                            else                  state_next       = ST_WAIT_EPOCH;
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_reg == CLR_W'(CLR_TOTAL)) begin
                    state_next   = ST_IDLE;
                    clr_cnt_next = '0;
                end else begin
                    lut_valid_next = 1'b1;
                    conf_data_next = DATA_W'(CHANNELS);
                    conf_sel_next  = SEL_W'(clr_cnt_reg / CLR_W'(LUT_SIZE));
                    conf_slot_next = SLOT_W'(clr_cnt_reg % CLR_W'(LUT_SIZE));
                    clr_cnt_next   = clr_cnt_reg + CLR_W'(1);
                end
            end
            ST_WAIT_EPOCH: begin
                if (epoch_start) begin
                    state_next = ST_APPLY;
                    apply_pop  = 1'b1;
                end
            end
            default: begin
                if (!fifo_empty) begin
                    apply_pop = 1'b1;
                end else begin
                    state_next       = ST_IDLE;
                    commit_done_next = 1'b1;
                end
            end
        endcase

        if (apply_pop) begin
            fifo_pop        = 1'b1;
            conf_data_next  = fifo_head.data;
            conf_sel_next   = fifo_head.sel;
            conf_slot_next  = fifo_head.slot;
            link_valid_next = fifo_head.is_link;
            lut_valid_next  = !fifo_head.is_link;
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n_sync_reg) begin
        if (!rst_n_sync_reg) begin
            state_reg       <= ST_IDLE;
            clr_cnt_reg     <= '0;
            conf_data_reg   <= '0;
            conf_sel_reg    <= '0;
            conf_slot_reg   <= '0;
            lut_valid_reg   <= 1'b0;
            link_valid_reg  <= 1'b0;
            commit_done_reg <= 1'b0;
            stage_ovf_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            clr_cnt_reg     <= clr_cnt_next;
            conf_data_reg   <= conf_data_next;
            conf_sel_reg    <= conf_sel_next;
            conf_slot_reg   <= conf_slot_next;
            lut_valid_reg   <= lut_valid_next;
            link_valid_reg  <= link_valid_next;
            commit_done_reg <= commit_done_next;
            stage_ovf_reg   <= stage_ovf_next;
        end
    end

    assign lut_conf_data  = conf_data_reg;
    assign lut_conf_sel   = conf_sel_reg;
    assign lut_conf_slot  = conf_slot_reg;
    assign lut_conf_valid = lut_valid_reg;
    assign link_en_valid  = link_valid_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign commit_done    = commit_done_reg;
    assign stage_ovf      = stage_ovf_reg;

endmodule
